// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS datapath: load-use stalls,
// branch flushes resolved in MEM, and freezing around a multi-cycle mult/div unit.
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_dst,
  input  logic             ex_md_op,
  input  logic             md_done,
  input  logic             mem_branch_taken,
  output logic             pc_write,
  output logic             pc_src_branch,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             md_go,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int TW = $clog2(MD_TIMEOUT + 1);
  localparam logic [TW-1:0]    T_LAST    = TW'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    MD_ERR  = 2'd2
  } state_t;

  state_t           state_r;
  logic [TW-1:0]    tcnt_r;
  logic             md_err_r;
  logic [CNT_W-1:0] stall_r;
  logic             lu_s;

  assign lu_s = ex_memread & (ex_dst != 5'd0) &
                ((ex_dst == id_rs) | (id_uses_rt & (ex_dst == id_rt)));

  // Mealy pipeline controls; everything is held low while in reset.
  always_comb begin
    pc_write      = 1'b1;
    pc_src_branch = 1'b0;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    md_go         = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          // A taken branch squashes the younger instructions, so their hazards do not matter.
          if (mem_branch_taken) begin
            pc_src_branch = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
          end else if (ex_md_op) begin
            md_go         = 1'b1;
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
          end else if (lu_s) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else begin
            pc_write = 1'b1;
          end
        end
        MD_WAIT: begin
          if (md_done) begin
            pc_write = 1'b1;
          end else begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
          end
        end
        default: begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
        end
      endcase
    end
  end

  // Sequencing FSM with the mult/div watchdog and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= RUN;
      tcnt_r   <= {TW{1'b0}};
      md_err_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (!mem_branch_taken && ex_md_op) begin
            state_r <= MD_WAIT;
            tcnt_r  <= TW'(1);
          end else begin
            state_r <= RUN;
            tcnt_r  <= {TW{1'b0}};
          end
        end
        MD_WAIT: begin
          if (md_done) begin
            state_r <= RUN;
            tcnt_r  <= {TW{1'b0}};
          end else if (tcnt_r == T_LAST) begin
            state_r  <= MD_ERR;
            md_err_r <= 1'b1;
          end else begin
            tcnt_r <= tcnt_r + TW'(1);
          end
        end
        MD_ERR: begin
          state_r  <= MD_ERR;
          md_err_r <= 1'b1;
        end
        default: begin
          state_r <= RUN;
          tcnt_r  <= {TW{1'b0}};
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_r <= {CNT_W{1'b0}};
    end else if (!pc_write && (stall_r != STALL_MAX)) begin
      stall_r <= stall_r + CNT_W'(1);
    end else begin
      stall_r <= stall_r;
    end
  end

  assign md_err       = md_err_r;
  assign stall_cycles = stall_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (default and small timeout/counter) checked
// every cycle against a behavioural model, plus directed literal expectations.
module tb_hazard_ctrl;

  localparam logic [7:0] C_DEF = 8'b1010_1000;
  localparam logic [7:0] C_BR  = 8'b1111_1110;
  localparam logic [7:0] C_GO  = 8'b0000_0011;
  localparam logic [7:0] C_LU  = 8'b0000_1100;
  localparam logic [7:0] C_FRZ = 8'b0000_0010;
  localparam int TMO  [2] = '{64, 4};
  localparam int SMAX [2] = '{65535, 7};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [4:0] id_rs = 5'd0, id_rt = 5'd0, ex_dst = 5'd0;
  logic id_uses_rt = 1'b0, ex_memread = 1'b0, ex_md_op = 1'b0;
  logic md_done = 1'b0, mem_branch_taken = 1'b0;

  logic a_pcw, a_src, a_ifw, a_fl, a_idw, a_bub, a_exb, a_go, a_err;
  logic b_pcw, b_src, b_ifw, b_fl, b_idw, b_bub, b_exb, b_go, b_err;
  logic [15:0] a_stall;
  logic [2:0]  b_stall;
  logic [7:0]  a_ctl, b_ctl;
  assign a_ctl = {a_pcw, a_src, a_ifw, a_fl, a_idw, a_bub, a_exb, a_go};
  assign b_ctl = {b_pcw, b_src, b_ifw, b_fl, b_idw, b_bub, b_exb, b_go};

  int checks = 0;
  int failures = 0;

  // model: is a mult/div outstanding, how long has it waited, has it timed out, stall count
  bit waiting [2];
  int wcnt    [2];
  bit dead    [2];
  int stalls  [2];

  always #5 clk = ~clk;

  hazard_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_dst(ex_dst), .ex_md_op(ex_md_op), .md_done(md_done),
    .mem_branch_taken(mem_branch_taken), .pc_write(a_pcw), .pc_src_branch(a_src),
    .if_id_write(a_ifw), .if_id_flush(a_fl), .id_ex_write(a_idw), .id_ex_bubble(a_bub),
    .ex_mem_bubble(a_exb), .md_go(a_go), .md_err(a_err), .stall_cycles(a_stall)
  );

  hazard_ctrl #(.MD_TIMEOUT(4), .CNT_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_dst(ex_dst), .ex_md_op(ex_md_op), .md_done(md_done),
    .mem_branch_taken(mem_branch_taken), .pc_write(b_pcw), .pc_src_branch(b_src),
    .if_id_write(b_ifw), .if_id_flush(b_fl), .id_ex_write(b_idw), .id_ex_bubble(b_bub),
    .ex_mem_bubble(b_exb), .md_go(b_go), .md_err(b_err), .stall_cycles(b_stall)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected control vector {pcw,src,ifw,flush,idw,bubble,exb,go} for instance i.
  function automatic logic [7:0] exp_ctl(input int i);
    bit lu;
    lu = ex_memread && ex_dst != 0 &&
         (ex_dst == id_rs || (id_uses_rt && ex_dst == id_rt));
    if (!rst_n) return 8'h00;
    if (dead[i]) return C_FRZ;
    if (waiting[i]) return md_done ? C_DEF : C_FRZ;
    if (mem_branch_taken) return C_BR;
    if (ex_md_op) return C_GO;
    if (lu) return C_LU;
    return C_DEF;
  endfunction

  // Model state advance on each clock; reset clears it immediately.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        waiting[i] <= 1'b0; wcnt[i] <= 0; dead[i] <= 1'b0; stalls[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [7:0] e;
        e = exp_ctl(i);
        if (!e[7] && stalls[i] < SMAX[i]) stalls[i] <= stalls[i] + 1;
        if (dead[i]) begin
          dead[i] <= 1'b1;
        end else if (waiting[i]) begin
          if (md_done) waiting[i] <= 1'b0;
          else if (wcnt[i] + 1 >= TMO[i]) begin
            dead[i] <= 1'b1; waiting[i] <= 1'b0;
          end else wcnt[i] <= wcnt[i] + 1;
        end else if (e[0]) begin
          waiting[i] <= 1'b1; wcnt[i] <= 1;
        end
      end
    end
  end

  // Compare both instances against the model mid-cycle.
  always @(negedge clk) begin
    chk("a_ctl", a_ctl, exp_ctl(0));
    chk("b_ctl", b_ctl, exp_ctl(1));
    chk("a_err", a_err, dead[0]);
    chk("b_err", b_err, dead[1]);
    chk("a_stall", a_stall, stalls[0]);
    chk("b_stall", b_stall, stalls[1]);
  end

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_dst = 5'd0; id_uses_rt = 1'b0; ex_memread = 1'b0;
    ex_md_op = 1'b0; md_done = 1'b0; mem_branch_taken = 1'b0;
  endtask
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic look(); @(negedge clk); #1; endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick(); tick();
    look();
    chk("rst_ctl", a_ctl, 0);
    chk("rst_stall", a_stall, 0);
    rst_n = 1'b1;
    tick();

    ex_memread = 1'b1; ex_dst = 5'd5; id_rs = 5'd5;
    look(); chk("lu_ctl", a_ctl, C_LU); tick();
    idle();
    look(); chk("lu_stall", a_stall, 1); chk("lu_once", a_ctl, C_DEF); tick();

    ex_memread = 1'b1; ex_dst = 5'd0; id_rs = 5'd0;
    look(); chk("lu_r0", a_ctl, C_DEF); tick();

    idle(); ex_memread = 1'b1; ex_dst = 5'd7; id_rt = 5'd7; id_rs = 5'd1;
    look(); chk("rt_unused", a_ctl, C_DEF); tick();
    id_uses_rt = 1'b1;
    look(); chk("rt_used", a_ctl, C_LU); tick();

    idle(); ex_memread = 1'b1; ex_dst = 5'd5; id_rs = 5'd5; ex_md_op = 1'b1; mem_branch_taken = 1'b1;
    look(); chk("br_pri", a_ctl, C_BR); tick();
    idle();
    look(); chk("br_stay_run", a_ctl, C_DEF); tick();

    for (int k = 0; k <= 10; k++) begin
      idle(); ex_md_op = (k == 0); md_done = (k == 10);
      look();
      chk("md_seq", a_ctl, (k == 0) ? C_GO : (k < 10) ? C_FRZ : C_DEF);
      chk("b_timeout", b_err, (k >= 4) ? 1 : 0);
      if (k == 10) chk("b_done_ignored", b_ctl, C_FRZ);
      tick();
    end
    idle();
    look();
    chk("md_stall", a_stall, 12);
    chk("md_back_run", a_ctl, C_DEF);
    chk("b_sat", b_stall, 7);
    chk("b_sticky", b_err, 1);
    rst_n = 1'b0;
    look();
    chk("rst_b_err", b_err, 0);
    chk("rst_force0", a_ctl, 0);
    tick();
    rst_n = 1'b1;
    look(); chk("b_no_rego", b_ctl, C_DEF); tick();

    for (int n = 0; n < 3000; n++) begin
      rst_n            = ($urandom_range(0, 59) != 0);
      id_rs            = 5'($urandom_range(0, 7));
      id_rt            = 5'($urandom_range(0, 7));
      ex_dst           = 5'($urandom_range(0, 7));
      id_uses_rt       = 1'($urandom_range(0, 1));
      ex_memread       = 1'($urandom_range(0, 1));
      ex_md_op         = ($urandom_range(0, 7) == 0);
      md_done          = ($urandom_range(0, 4) == 0);
      mem_branch_taken = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
